// File: rtl/muxn_rr_reg.sv
// rtl/muxn_rr_reg.sv - N-channel valid/ready selector with fixed or round-robin grant and registered output
module muxn_rr_reg #(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_ch,
  input  logic           out_ready
);

  localparam logic [SW:0] N_EXT = (SW+1)'(N);

  logic          load_en;
  logic          grant_v;
  logic [SW-1:0] grant;
  logic [W-1:0]  grant_data;
  logic [SW-1:0] ptr;
  logic [SW:0]   idx;

  assign load_en = !out_valid || out_ready;

  always_comb begin
    grant   = '0;
    grant_v = 1'b0;
    idx     = '0;
    if (!mode) begin
      // sel values >= N match no channel, so they simply produce no grant
      for (int i = 0; i < N; i++) begin
        if (sel == SW'(i)) begin
          grant   = SW'(i);
          grant_v = in_valid[i];
        end
      end
    end else begin
      // Walk from the farthest candidate back to ptr so the nearest valid one wins
      for (int k = N-1; k >= 0; k--) begin
        idx = {1'b0, ptr} + (SW+1)'(k);
        if (idx >= N_EXT) idx = idx - N_EXT;
        for (int i = 0; i < N; i++) begin
          if (idx == (SW+1)'(i) && in_valid[i]) begin
            grant   = SW'(i);
            grant_v = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant == SW'(i)) grant_data = in_data[i*W +: W];
    end
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = rst_n && load_en && grant_v && (grant == SW'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else if (load_en) begin
      if (grant_v) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_ch    <= grant;
        ptr       <= (grant == SW'(N-1)) ? '0 : grant + SW'(1);
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_muxn_rr_reg.sv
// tb/tb_muxn_rr_reg.sv - directed self-checking bench for muxn_rr_reg (N=4, W=8)
module tb_muxn_rr_reg;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           mode;
  logic [SW-1:0]  sel;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_ch;
  logic           out_ready;

  int total  = 0;
  int passed = 0;

  muxn_rr_reg #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] c);
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    check({tag, ".data"},  32'(out_data),  32'(d));
    check({tag, ".ch"},    32'(out_ch),    32'(c));
  endtask

  initial begin
    rst_n     = 1'b0;
    mode      = 1'b0;
    sel       = 2'd0;
    in_valid  = 4'b1111;
    in_data   = '0;
    out_ready = 1'b1;
    #1;
    check("reset.in_ready", 32'(in_ready), 32'h0);
    check_out("reset", 1'b0, 8'h00, 2'd0);
    #2 rst_n = 1'b1;

    // Fixed select of channel 2
    step();
    sel      = 2'd2;
    in_valid = 4'b0110;
    in_data  = {8'h44, 8'hA5, 8'h22, 8'h11};
    #1;
    check("fixed.in_ready", 32'(in_ready), 32'h4);
    step();
    check_out("fixed", 1'b1, 8'hA5, 2'd2);

    // Asynchronous reset in the middle of a cycle while holding a word
    in_valid = 4'b0000;
    #2 rst_n = 1'b0;
    #1;
    check_out("async_rst", 1'b0, 8'h00, 2'd0);
    #1 rst_n = 1'b1;

    // Round robin over all four channels starting from ptr=0
    mode     = 1'b1;
    in_valid = 4'b1111;
    in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("rr_all.in_ready%0d", i), 32'(in_ready), 32'(1) << (i % 4));
      step();
      check_out($sformatf("rr_all%0d", i), 1'b1, 8'(8'h10 + (i % 4)), 2'(i % 4));
    end

    // ptr is 1 now; one grant of ch1 moves it to 2
    in_valid = 4'b0010;
    step();
    check_out("rr_setup", 1'b1, 8'h11, 2'd1);
    in_valid = 4'b1010;
    #1;
    check("rr_sparse.in_ready0", 32'(in_ready), 32'h8);
    step();
    check_out("rr_sparse0", 1'b1, 8'h13, 2'd3);
    #1;
    check("rr_sparse.in_ready1", 32'(in_ready), 32'h2);
    step();
    check_out("rr_sparse1", 1'b1, 8'h11, 2'd1);
    step();
    check_out("rr_sparse2", 1'b1, 8'h13, 2'd3);

    // Backpressure: hold 0x5A from ch0 for three cycles, then load ch1 with no bubble
    mode     = 1'b0;
    sel      = 2'd0;
    in_valid = 4'b0001;
    in_data  = {8'h13, 8'h12, 8'h77, 8'h5A};
    step();
    check_out("bp_load", 1'b1, 8'h5A, 2'd0);
    out_ready = 1'b0;
    sel       = 2'd1;
    in_valid  = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("bp.in_ready%0d", i), 32'(in_ready), 32'h0);
      step();
      check_out($sformatf("bp_hold%0d", i), 1'b1, 8'h5A, 2'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release.in_ready", 32'(in_ready), 32'h2);
    step();
    check_out("bp_release", 1'b1, 8'h77, 2'd1);

    // Fixed select on an idle channel: no grant, output drains but keeps data/ch
    sel      = 2'd2;
    in_valid = 4'b1011;
    #1;
    check("idle_sel.in_ready", 32'(in_ready), 32'h0);
    step();
    check_out("drain", 1'b0, 8'h77, 2'd1);
    step();
    check("drain2.in_ready", 32'(in_ready), 32'h0);
    check_out("drain2", 1'b0, 8'h77, 2'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
